// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM for the multi-cycle RISC-V core
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [1:0] alu_op,
    output logic       illegal_instr
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = S_FETCH;
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        reg_write     = 1'b0;
        alu_op        = 2'b00;
        illegal_instr = 1'b0;

        case (opcode)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase

        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = mem_ready;
                ir_write   = mem_ready;
                state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
                        state_next    = S_FETCH;
                        illegal_instr = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = zero;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Reset abandons whatever was in flight: FETCH-shaped outputs, no writes.
        if (reset) begin
            state_next    = S_FETCH;
            pc_write      = 1'b0;
            adr_src       = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            result_src    = 2'b10;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b10;
            reg_write     = 1'b0;
            alu_op        = 2'b00;
            illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       illegal_instr;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .reg_write(reg_write), .alu_op(alu_op),
        .illegal_instr(illegal_instr)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef enum {
        PH_RESET, PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMREAD, PH_MEMWB,
        PH_MEMWRITE, PH_EXECR, PH_EXECI, PH_ALUWB, PH_BEQ, PH_JAL
    } phase_t;

    typedef struct {
        logic [15:0] vec;
        phase_t      ph;
        int          instr_no;
    } exp_t;

    exp_t q[$];
    int   tests;
    int   fails;
    int   instr_count;

    // Packed view: pc,adr,memw,irw,res[2],a[2],b[2],imm[2],regw,aluop[2],ill
    function automatic logic [15:0] pack(logic pcw, logic adr, logic mw, logic irw,
                                         logic [1:0] res, logic [1:0] a, logic [1:0] b,
                                         logic [1:0] imm, logic rw, logic [1:0] op,
                                         logic ill);
        return {pcw, adr, mw, irw, res, a, b, imm, rw, op, ill};
    endfunction

    function automatic logic supported(logic [6:0] opc);
        return opc inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1100011, 7'b1101111};
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] opc);
        if (opc == 7'b0100011) return 2'b01;
        if (opc == 7'b1100011) return 2'b10;
        if (opc == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // What the datapath should see in each phase of an instruction.
    function automatic logic [15:0] expect_vec(phase_t ph, logic [6:0] opc, logic mr, logic z);
        logic [1:0] im;
        im = imm_of(opc);
        case (ph)
            PH_RESET:    return pack(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, im, 0, 2'b00, 0);
            PH_FETCH:    return pack(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, im, 0, 2'b00, 0);
            PH_DECODE:   return pack(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 0, 2'b00, !supported(opc));
            PH_MEMADR:   return pack(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 0, 2'b00, 0);
            PH_MEMREAD:  return pack(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, 0, 2'b00, 0);
            PH_MEMWB:    return pack(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, im, 1, 2'b00, 0);
            PH_MEMWRITE: return pack(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, im, 0, 2'b00, 0);
            PH_EXECR:    return pack(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, 0, 2'b10, 0);
            PH_EXECI:    return pack(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 0, 2'b10, 0);
            PH_ALUWB:    return pack(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 1, 2'b00, 0);
            PH_BEQ:      return pack(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, 0, 2'b01, 0);
            PH_JAL:      return pack(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, 0, 2'b00, 0);
            default:     return 16'h0;
        endcase
    endfunction

    // Drive one cycle of inputs and queue the response expected during it.
    task automatic drive(logic rst, logic [6:0] opc, logic mr, logic z, phase_t ph);
        exp_t e;
        reset     = rst;
        opcode    = opc;
        mem_ready = mr;
        zero      = z;
        e.vec      = expect_vec(ph, opc, mr, z);
        e.ph       = ph;
        e.instr_no = instr_count;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Expand an instruction into its phase walk, then play it (optionally aborting by reset).
    task automatic run_instr(logic [6:0] opc, int fw, int mw, logic bz, int abort_at);
        phase_t ph_q[$];
        logic   mr_q[$];
        logic   z;
        instr_count++;
        repeat (fw) begin ph_q.push_back(PH_FETCH); mr_q.push_back(1'b0); end
        ph_q.push_back(PH_FETCH);  mr_q.push_back(1'b1);
        ph_q.push_back(PH_DECODE); mr_q.push_back(1'($urandom));
        case (opc)
            7'b0000011: begin
                ph_q.push_back(PH_MEMADR); mr_q.push_back(1'($urandom));
                repeat (mw) begin ph_q.push_back(PH_MEMREAD); mr_q.push_back(1'b0); end
                ph_q.push_back(PH_MEMREAD); mr_q.push_back(1'b1);
                ph_q.push_back(PH_MEMWB);   mr_q.push_back(1'($urandom));
            end
            7'b0100011: begin
                ph_q.push_back(PH_MEMADR); mr_q.push_back(1'($urandom));
                repeat (mw) begin ph_q.push_back(PH_MEMWRITE); mr_q.push_back(1'b0); end
                ph_q.push_back(PH_MEMWRITE); mr_q.push_back(1'b1);
            end
            7'b0110011: begin
                ph_q.push_back(PH_EXECR); mr_q.push_back(1'($urandom));
                ph_q.push_back(PH_ALUWB); mr_q.push_back(1'($urandom));
            end
            7'b0010011: begin
                ph_q.push_back(PH_EXECI); mr_q.push_back(1'($urandom));
                ph_q.push_back(PH_ALUWB); mr_q.push_back(1'($urandom));
            end
            7'b1100011: begin
                ph_q.push_back(PH_BEQ); mr_q.push_back(1'($urandom));
            end
            7'b1101111: begin
                ph_q.push_back(PH_JAL);   mr_q.push_back(1'($urandom));
                ph_q.push_back(PH_ALUWB); mr_q.push_back(1'($urandom));
            end
            default: ;
        endcase
        for (int i = 0; i < ph_q.size(); i++) begin
            z = (ph_q[i] == PH_BEQ) ? bz : 1'($urandom);
            if (i == abort_at) begin
                drive(1'b1, opc, mr_q[i], z, PH_RESET);
                return;
            end
            drive(1'b0, opc, mr_q[i], z, ph_q[i]);
        end
    endtask

    // Monitor: every cycle the DUT presents a response, compare against the queue head.
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e   = q.pop_front();
                act = pack(pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                           alu_src_b, imm_src, reg_write, alu_op, illegal_instr);
                tests++;
                if (act !== e.vec) begin
                    fails++;
                    $display("FAIL outputs instr %0d phase %s: got %b expected %b",
                             e.instr_no, e.ph.name(), act, e.vec);
                end
            end
        end
    end

    logic [6:0] op_tab [0:7];

    initial begin
        int sel;
        int abort;
        tests = 0; fails = 0; instr_count = 0;
        op_tab[0] = 7'b0000011; op_tab[1] = 7'b0100011; op_tab[2] = 7'b0110011;
        op_tab[3] = 7'b0010011; op_tab[4] = 7'b1100011; op_tab[5] = 7'b1101111;
        op_tab[6] = 7'b1111111; op_tab[7] = 7'b0000000;
        reset = 1'b1; opcode = 7'b0110011; mem_ready = 1'b1; zero = 1'b0;
        #1;
        drive(1'b1, 7'b0110011, 1'b1, 1'b0, PH_RESET);
        drive(1'b1, 7'b0110011, 1'b1, 1'b0, PH_RESET);

        run_instr(7'b0110011, 0, 0, 1'b0, -1);  // R-type
        run_instr(7'b0000011, 2, 3, 1'b0, -1);  // lw with waits, 10 cycles
        run_instr(7'b0100011, 0, 1, 1'b0, -1);  // sw, one wait
        run_instr(7'b1100011, 0, 0, 1'b1, -1);  // beq taken
        run_instr(7'b1100011, 0, 0, 1'b0, -1);  // beq not taken
        run_instr(7'b1101111, 0, 0, 1'b0, -1);  // jal
        run_instr(7'b1111111, 0, 0, 1'b0, -1);  // illegal
        run_instr(7'b0010011, 1, 0, 1'b0, -1);  // I-type
        run_instr(7'b0100011, 0, 2, 1'b0, 3);   // reset during MEMWRITE wait
        run_instr(7'b0000011, 0, 0, 1'b0, -1);  // recovers cleanly

        for (int n = 0; n < 400; n++) begin
            sel   = $urandom_range(0, 7);
            abort = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8) : -1;
            run_instr(op_tab[sel], $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), abort);
        end

        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle variant of the RISC-V core. One shared ALU and one unified instruction/data memory; the FSM steps each instruction through Fetch/Decode/Execute/Memory/Writeback.
- Drives ALUOp to the existing ALU decoder, plus all datapath mux selects and write enables.
- Adds a memory-ready wait handshake and illegal-opcode flagging.

Parameters:
- STATE_W, 4, width of state register (11 states used).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- opcode  input  7  instr[6:0] from instruction register
- zero  input  1  ALU zero flag, valid in BEQ state
- mem_ready  input  1  memory access completes this cycle
- pc_write  output  1  PC register enable
- adr_src  output  1  memory address select: 0=PC, 1=Result
- mem_write  output  1  data memory write strobe
- ir_write  output  1  instruction register / OldPC enable
- result_src  output  2  00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  output  2  00=PC, 01=OldPC, 10=RD1
- alu_src_b  output  2  00=RD2, 01=ImmExt, 10=const 4
- imm_src  output  2  00=I, 01=S, 10=B, 11=J
- reg_write  output  1  register file write enable
- alu_op  output  2  00=add, 01=sub, 10=funct-decoded
- illegal_instr  output  1  one-cycle pulse on unsupported opcode

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Reset: state<=FETCH on the clk edge with reset=1. While reset=1, pc_write, mem_write, ir_write, reg_write and illegal_instr are forced to 0. Other outputs take FETCH values.
- Reset asserted mid-instruction: abandon immediately. No write enable may assert in the reset cycle.
- Outputs are Moore, decoded from state. Exceptions:
  - pc_write and ir_write are gated by mem_ready in FETCH.
  - pc_write depends on zero in BEQ.
  - imm_src is combinational from opcode in every state.
- Unlisted outputs are 0.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write=pc_write=mem_ready.
  - mem_ready=0: stay in FETCH. mem_ready=1: go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other opcode -> FETCH with illegal_instr=1 for this cycle only. No architectural write occurs.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: result_src=00, adr_src=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1 every cycle held. Hold until mem_ready=1, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Next ALUWB.
- ALUWB: result_src=00, reg_write=1. Next FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero. Next FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next ALUWB (rd<=PC+4).
- imm_src by opcode: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, others -> 00.
- Latencies with mem_ready=1 throughout: R/I=4 cycles, lw=5, sw=4, beq=3, jal=4.
- Unreachable state encodings: next state FETCH, all enables 0.
- Opcode is sampled only from the IR. The IR is stable outside FETCH, so no opcode latching is required.

Test Plan:
- Reset: hold reset 2 cycles with mem_ready=1 -> state FETCH; pc_write=ir_write=reg_write=mem_write=0 throughout; first post-reset cycle gives ir_write=pc_write=1, alu_src_b=10.
- R-type: opcode=0110011, mem_ready=1 -> FETCH, DECODE, EXECR (alu_op=10, alu_src_a=10, alu_src_b=00), ALUWB (reg_write=1, result_src=00), FETCH; exactly one reg_write pulse.
- lw with waits: opcode=0000011; mem_ready low 2 cycles in FETCH and 3 cycles in MEMREAD -> ir_write only on ready cycle; MEMREAD adr_src=1 held 4 cycles; MEMWB reg_write=1, result_src=01; total 10 cycles.
- sw: opcode=0100011, imm_src=01; MEMWRITE with mem_ready low 1 cycle -> mem_write=1 for 2 cycles, then FETCH; reg_write never 1.
- beq: opcode=1100011, imm_src=10; zero=1 -> pc_write=1 in BEQ; repeat with zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
- jal, illegal opcode, mid-op reset:
  - jal opcode=1101111 -> JAL pc_write=1, then ALUWB reg_write=1.
  - opcode=1111111 -> illegal_instr=1 for one cycle in DECODE, back to FETCH, no writes.
  - reset asserted during MEMWRITE with mem_ready=0 -> mem_write=0 that cycle, FETCH next.
